// File: rtl/dp_noise_controller.sv
// Privacy-budget gate around a CNN query: deducts budget per query and drives noise injection.
// Define DP_WATCHDOG_EN to abort a stalled CNN after TIMEOUT_CYCLES with result_error set.
module dp_noise_controller #(
    parameter int unsigned BUDGET_MAX     = 15,
    parameter int unsigned COST_CLEAN     = 4,
    parameter int unsigned COST_NOISY     = 1,
    parameter int unsigned REFILL_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             query_valid,
    output logic                             query_ready,
    input  logic                             privacy_mode,
    output logic                             cnn_start,
    input  logic                             cnn_done,
    output logic                             inject_noise,
    input  logic [3:0]                       class_in,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [3:0]                       result_class,
    output logic                             result_noisy,
    output logic                             result_error,
    output logic [$clog2(BUDGET_MAX+1)-1:0]  budget,
    output logic                             locked
);

    localparam int unsigned BW = $clog2(BUDGET_MAX + 1);
    localparam int unsigned RW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

    localparam logic [BW-1:0] BudgetMax  = BW'(BUDGET_MAX);
    localparam logic [BW-1:0] CostClean  = BW'(COST_CLEAN);
    localparam logic [BW-1:0] CostNoisy  = BW'(COST_NOISY);
    localparam logic [RW-1:0] RefillLast = RW'(REFILL_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StCapture,
        StResp
    } state_e;

    state_e        state_q;
    logic [RW-1:0] refill_cnt_q;
    logic          accept;
    logic          noisy;
    logic          refill_tick;
    logic [BW-1:0] cost;
    logic [BW-1:0] budget_d;
    int            budget_sum;

`ifdef DP_WATCHDOG_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] TimeoutLast = WW'(TIMEOUT_CYCLES);

    logic [WW-1:0] wd_cnt_q;
    logic          result_error_q;

    assign result_error = result_error_q;
`else
    assign result_error = 1'b0;
`endif

    // Gated by reset so nothing can be accepted on the reset edge itself.
    assign query_ready = !reset && (state_q == StIdle) && (budget >= CostNoisy);
    assign accept      = query_valid && query_ready;
    assign noisy       = privacy_mode || (budget < CostClean);
    assign cost        = noisy ? CostNoisy : CostClean;
    assign refill_tick = (refill_cnt_q == RefillLast);
    assign locked      = (budget == '0);

    // Refill and deduction landing on the same edge combine into one saturated update.
    always_comb begin
        budget_sum = int'(budget) + int'(refill_tick);
        if (accept) begin
            budget_sum = budget_sum - int'(cost);
        end
        if (budget_sum < 0) begin
            budget_d = '0;
        end else if (budget_sum > int'(BUDGET_MAX)) begin
            budget_d = BudgetMax;
        end else begin
            budget_d = BW'(budget_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            budget         <= BudgetMax;
            refill_cnt_q   <= '0;
            cnn_start      <= 1'b0;
            inject_noise   <= 1'b0;
            result_valid   <= 1'b0;
            result_class   <= 4'h0;
            result_noisy   <= 1'b0;
`ifdef DP_WATCHDOG_EN
            wd_cnt_q       <= '0;
            result_error_q <= 1'b0;
`endif
        end else begin
            budget       <= budget_d;
            refill_cnt_q <= refill_tick ? '0 : refill_cnt_q + 1'b1;
            cnn_start    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q      <= StStart;
                        cnn_start    <= 1'b1;
                        inject_noise <= noisy;
                    end
                end
                StStart: begin
                    state_q <= StWait;
`ifdef DP_WATCHDOG_EN
                    wd_cnt_q <= '0;
`endif
                end
                StWait: begin
                    if (cnn_done) begin
                        state_q <= StCapture;
`ifdef DP_WATCHDOG_EN
                    end else if (wd_cnt_q == TimeoutLast) begin
                        state_q        <= StResp;
                        result_valid   <= 1'b1;
                        result_class   <= 4'hF;
                        result_noisy   <= inject_noise;
                        result_error_q <= 1'b1;
                        inject_noise   <= 1'b0;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
`endif
                    end
                end
                StCapture: begin
                    // class_in is the injector's registered output, valid one cycle after done.
                    state_q      <= StResp;
                    result_valid <= 1'b1;
                    result_class <= class_in;
                    result_noisy <= inject_noise;
                    inject_noise <= 1'b0;
`ifdef DP_WATCHDOG_EN
                    result_error_q <= 1'b0;
`endif
                end
                StResp: begin
                    if (result_ready) begin
                        state_q      <= StIdle;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_noise_controller.sv
// Bench for dp_noise_controller: vector table, hand sequences and a randomized run against
// a transaction-level budget model. Define DP_WATCHDOG_EN to also exercise the timeout path.
module tb_dp_noise_controller;

    localparam int BMAX = 15;
    localparam int CC   = 4;
    localparam int CN   = 1;
    localparam int R    = 128;
    localparam int TO   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       query_valid;
    logic       query_ready;
    logic       privacy_mode;
    logic       cnn_start;
    logic       cnn_done;
    logic       inject_noise;
    logic [3:0] class_in;
    logic       result_valid;
    logic       result_ready;
    logic [3:0] result_class;
    logic       result_noisy;
    logic       result_error;
    logic [3:0] budget;
    logic       locked;

    dp_noise_controller #(
        .BUDGET_MAX    (BMAX),
        .COST_CLEAN    (CC),
        .COST_NOISY    (CN),
        .REFILL_CYCLES (R),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .query_valid  (query_valid),
        .query_ready  (query_ready),
        .privacy_mode (privacy_mode),
        .cnn_start    (cnn_start),
        .cnn_done     (cnn_done),
        .inject_noise (inject_noise),
        .class_in     (class_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_noisy (result_noisy),
        .result_error (result_error),
        .budget       (budget),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: budget, cycles since reset, and whether a query may be accepted / is responding.
    int m_budget = BMAX;
    int m_cyc    = 0;
    bit m_idle   = 1'b1;
    bit m_inresp = 1'b0;
    bit m_noisy  = 1'b0;

    typedef struct {
        bit         pm;
        int         dly;
        logic [3:0] cls;
        int         hold;
        bit         spur;
        bit         exp_noisy;
        int         exp_budget;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge, model update, then the always-valid output checks.
    task automatic tick();
        bit acc;
        bit hs;
        bit nz;
        int sum;
        acc = !reset && query_valid && m_idle && (m_budget >= CN);
        hs  = !reset && m_inresp && result_ready;
        nz  = privacy_mode || (m_budget < CC);
        @(posedge clk);
        if (reset) begin
            m_budget = BMAX;
            m_cyc    = 0;
            m_idle   = 1'b1;
            m_inresp = 1'b0;
        end else begin
            m_cyc++;
            sum = m_budget;
            if (acc) begin
                m_noisy = nz;
                sum     = sum - (nz ? CN : CC);
                m_idle  = 1'b0;
            end
            if (m_cyc % R == 0) sum = sum + 1;
            m_budget = (sum < 0) ? 0 : ((sum > BMAX) ? BMAX : sum);
            if (hs) begin
                m_idle   = 1'b1;
                m_inresp = 1'b0;
            end
        end
        #1;
        check("cnn_start", cnn_start, acc);
        check("budget", budget, m_budget);
        check("locked", locked, m_budget == 0);
        check("query_ready", query_ready, !reset && m_idle && (m_budget >= CN));
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        query_valid  = 1'b0;
        cnn_done     = 1'b0;
        result_ready = 1'b0;
        tick();
        check("rst_query_ready", query_ready, 1'b0);
        check("rst_inject_noise", inject_noise, 1'b0);
        check("rst_result_valid", result_valid, 1'b0);
        check("rst_result_class", result_class, 4'h0);
        check("rst_result_noisy", result_noisy, 1'b0);
        check("rst_result_error", result_error, 1'b0);
        check("rst_budget", budget, BMAX);
        reset = 1'b0;
        #1;
        check("post_rst_query_ready", query_ready, 1'b1);
    endtask

    // Full query from acceptance to handshake; assumes the model says the DUT is ready.
    task automatic do_query(input bit pm, input int dly, input logic [3:0] cls, input int hold,
                            input bit spur, output bit got_noisy, output int lat);
        int acc_cyc;
        query_valid  = 1'b1;
        privacy_mode = pm;
        acc_cyc      = m_cyc;
        tick();
        query_valid  = 1'b0;
        privacy_mode = ~pm;
        check("inject_start", inject_noise, m_noisy);
        cnn_done = spur;
        tick();
        cnn_done = 1'b0;
        for (int i = 1; i <= dly; i++) begin
            check("inject_wait", inject_noise, m_noisy);
            check("valid_wait", result_valid, 1'b0);
            if (i == dly) cnn_done = 1'b1;
            class_in = 4'($urandom);
            tick();
        end
        cnn_done = 1'b0;
        class_in = cls;
        check("inject_capture", inject_noise, m_noisy);
        check("valid_capture", result_valid, 1'b0);
        tick();
        class_in = ~cls;
        m_inresp = 1'b1;
        got_noisy = result_noisy;
        check("resp_valid", result_valid, 1'b1);
        check("resp_class", result_class, cls);
        check("resp_noisy", result_noisy, m_noisy);
        check("resp_error", result_error, 1'b0);
        check("resp_inject", inject_noise, 1'b0);
        query_valid  = 1'b1;
        privacy_mode = 1'($urandom);
        cnn_done     = spur;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_valid", result_valid, 1'b1);
            check("bp_class", result_class, cls);
            check("bp_noisy", result_noisy, m_noisy);
        end
        query_valid  = 1'b0;
        result_ready = 1'b1;
        lat = m_cyc - acc_cyc + 1;
        tick();
        result_ready = 1'b0;
        cnn_done     = 1'b0;
        check("idle_valid", result_valid, 1'b0);
        check("idle_inject", inject_noise, 1'b0);
    endtask

    // From a locked state, wait for the next refill tick and check the unlock edge.
    task automatic wait_refill();
        query_valid = 1'b1;
        while (m_cyc < R - 1) tick();
        query_valid = 1'b0;
        check("pre_refill_budget", budget, 0);
        check("pre_refill_ready", query_ready, 1'b0);
        tick();
        check("refill_budget", budget, 1);
        check("refill_ready", query_ready, 1'b1);
        check("refill_locked", locked, 1'b0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL global_timeout: still running at %0t, required to finish", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        bit got_noisy;
        int lat;
        reset        = 1'b1;
        query_valid  = 1'b0;
        privacy_mode = 1'b0;
        cnn_done     = 1'b0;
        class_in     = 4'h0;
        result_ready = 1'b0;

        vecs[0] = '{1'b0, 3, 4'h7, 0,  1'b0, 1'b0, 11};
        vecs[1] = '{1'b0, 1, 4'hC, 10, 1'b1, 1'b0, 7};
        vecs[2] = '{1'b0, 2, 4'h0, 1,  1'b1, 1'b0, 3};
        vecs[3] = '{1'b0, 1, 4'h9, 0,  1'b0, 1'b1, 2};
        vecs[4] = '{1'b1, 4, 4'hE, 3,  1'b1, 1'b1, 1};
        vecs[5] = '{1'b0, 1, 4'hF, 0,  1'b0, 1'b1, 0};

        #1;
        do_reset();

        foreach (vecs[k]) begin
            do_query(vecs[k].pm, vecs[k].dly, vecs[k].cls, vecs[k].hold, vecs[k].spur,
                     got_noisy, lat);
            check("vec_noisy", got_noisy, vecs[k].exp_noisy);
            check("vec_budget", budget, vecs[k].exp_budget);
            check("vec_latency", lat, 4 + vecs[k].dly + vecs[k].hold);
            tick();
        end
        check("table_locked", locked, 1'b1);
        check("table_ready", query_ready, 1'b0);
        wait_refill();

        // Fifteen back-to-back noisy queries drain a full budget before any refill.
        do_reset();
        for (int q = 0; q < 15; q++) begin
            do_query(1'b1, 1, 4'(q), 0, 1'b0, got_noisy, lat);
            if (q == 0) check("min_latency", lat, 5);
        end
        check("lockout_budget", budget, 0);
        check("lockout_locked", locked, 1'b1);
        check("lockout_ready", query_ready, 1'b0);
        wait_refill();

        // Reset while waiting on the CNN, then a late cnn_done must be ignored.
        do_reset();
        query_valid  = 1'b1;
        privacy_mode = 1'b0;
        tick();
        query_valid = 1'b0;
        tick();
        tick();
        check("midwait_budget", budget, BMAX - CC);
        do_reset();
        check("midwait_rst_budget", budget, BMAX);
        cnn_done = 1'b1;
        tick();
        cnn_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("late_done_valid", result_valid, 1'b0);
            check("late_done_inject", inject_noise, 1'b0);
        end

        // Randomized traffic against the model.
        for (int it = 0; it < 500; it++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (m_budget >= CN) begin
                do_query(($urandom_range(0, 2) == 0), int'($urandom_range(1, 4)),
                         4'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                         got_noisy, lat);
            end else begin
                query_valid = 1'b1;
                tick();
                query_valid = 1'b0;
            end
        end

`ifdef DP_WATCHDOG_EN
        do_reset();
        query_valid  = 1'b1;
        privacy_mode = 1'b1;
        tick();
        query_valid = 1'b0;
        tick();
        for (int i = 1; i <= TO; i++) begin
            tick();
            check("wd_pending_valid", result_valid, 1'b0);
        end
        tick();
        m_inresp = 1'b1;
        check("wd_valid", result_valid, 1'b1);
        check("wd_error", result_error, 1'b1);
        check("wd_class", result_class, 4'hF);
        check("wd_noisy", result_noisy, 1'b1);
        check("wd_inject", inject_noise, 1'b0);
        check("wd_budget", budget, BMAX - CN);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("wd_idle_valid", result_valid, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dp_noise_controller.md
DP_NOISE_CONTROLLER -- requirements
Module: dp_noise_controller

Interface
REQ-001 SHALL have parameter BUDGET_MAX, default 15: privacy-budget ceiling, in units.
REQ-002 SHALL have parameter COST_CLEAN, default 4: budget cost of a clean (un-noised) query.
REQ-003 SHALL have parameter COST_NOISY, default 1: budget cost of a noised query.
REQ-004 SHALL have parameter REFILL_CYCLES, default 1024: number of cycles per +1 budget refill.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit, used only with REQ-030.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-008 SHALL have port query_valid, input, 1: requester presents a query.
REQ-009 SHALL have port query_ready, output, 1: controller accepts the query this cycle.
REQ-010 SHALL have port privacy_mode, input, 1: 1 requests noise; 0 requests a clean result. Sampled on acceptance.
REQ-011 SHALL have ports cnn_start (output, 1, one-cycle start pulse to the CNN) and cnn_done (input, 1, CNN completion).
REQ-012 SHALL have ports inject_noise (output, 1, drive to the noise injector) and class_in (input, 4, registered class from the injector).
REQ-013 SHALL have ports result_valid (output, 1), result_ready (input, 1), result_class (output, 4), result_noisy (output, 1) and result_error (output, 1).
REQ-014 SHALL have ports budget (output, clog2(BUDGET_MAX+1), current budget) and locked (output, 1, budget==0).

Function
REQ-015 SHALL implement the FSM states IDLE, START, WAIT, CAPTURE and RESP.
- IDLE->START on query_valid && query_ready.
- START->WAIT unconditionally.
- WAIT->CAPTURE on cnn_done.
- CAPTURE->RESP unconditionally.
- RESP->IDLE on result_ready.
REQ-016 SHALL assert query_ready only in IDLE with budget>=COST_NOISY, so no query is accepted when locked.
REQ-017 SHALL decide on acceptance: noisy = privacy_mode || (budget < COST_CLEAN). The cost is COST_NOISY if noisy, else COST_CLEAN, and is deducted from budget on the acceptance cycle.
REQ-018 SHALL assert cnn_start for exactly one cycle, in START.
REQ-019 SHALL hold inject_noise = noisy from START through CAPTURE inclusive, and drive it 0 in IDLE and RESP.
REQ-020 SHALL sample class_in in CAPTURE, one cycle after cnn_done, to match the injector's registered output. result_class and result_noisy SHALL then hold stable throughout RESP.
REQ-021 SHALL assert result_valid only in RESP. The transfer occurs on result_valid && result_ready. With result_ready held 1, the result SHALL complete 1 cycle after entering RESP.
REQ-022 SHALL ignore cnn_done outside WAIT.
REQ-023 SHALL implement a refill counter that runs continuously and adds +1 to budget every REFILL_CYCLES cycles, saturating at BUDGET_MAX. The counter SHALL keep running while budget is at BUDGET_MAX.
REQ-024 SHALL apply refill and deduction in the same cycle as a net change (budget - cost + 1), saturated to 0..BUDGET_MAX.
REQ-025 SHALL drive locked = (budget==0) combinationally from the budget register.
REQ-026 SHALL produce a minimum query latency of 5 cycles, measured from acceptance to the result_valid && result_ready handshake, when cnn_done arrives in the first WAIT cycle.

Reset
REQ-027 SHALL, with reset high at a clk edge, return to IDLE and set budget=BUDGET_MAX, refill counter=0, cnn_start=0, inject_noise=0, result_valid=0, result_class=0, result_noisy=0 and result_error=0.
REQ-028 SHALL, on reset mid-query in any state, abandon the query without issuing a result or refunding budget, and restore the budget to BUDGET_MAX.
REQ-029 SHALL drive query_ready=0 during the reset cycle.

Configuration
REQ-030 SHALL, with DP_WATCHDOG_EN defined, count cycles in WAIT. When the count reaches TIMEOUT_CYCLES without cnn_done, the FSM SHALL go to RESP with result_class=4'hF, result_error=1 and result_noisy=inject_noise, and the deducted budget SHALL not be refunded.
REQ-031 SHALL, without DP_WATCHDOG_EN, wait in WAIT indefinitely, tie result_error to 0, and ignore TIMEOUT_CYCLES.

Verification
REQ-032 SHALL cover a clean query: budget=15, privacy_mode=0, cnn_done 3 cycles after cnn_start, class_in=4'h7 -> inject_noise=0, result_class=7, result_noisy=0, budget=11.
REQ-033 SHALL cover a forced-noise query: budget=3, privacy_mode=0 -> inject_noise=1, result_noisy=1, budget=2.
REQ-034 SHALL cover lockout: 15 back-to-back noisy queries from budget=15 with no refill elapsed -> budget=0, locked=1, query_ready=0. After REFILL_CYCLES -> budget=1 and query_ready=1.
REQ-035 SHALL cover backpressure: result_ready held 0 for 10 cycles in RESP -> result_valid stays 1, result_class is stable, and no new query is accepted.
REQ-036 SHALL cover reset mid-WAIT: reset pulsed while waiting for cnn_done -> IDLE, budget=15, no result_valid, and a late cnn_done is ignored.
REQ-037 SHALL cover the watchdog, with DP_WATCHDOG_EN and TIMEOUT_CYCLES=8: no cnn_done -> result_error=1 and result_class=4'hF, with result_valid asserted 9 cycles after entering WAIT.
